// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: issues one bundle-aligned I-cache request at a time,
// holds the returned bundle for downstream, and squashes in-flight work on redirect.
module ifetch_ctrl #(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [63:0] PC_RESET    = 64'h8000_0000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [63:0]               pc_nxt,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      ireq_valid,
    output logic [63:0]               ireq_addr,
    input  logic                      ireq_ready,
    input  logic                      iresp_valid,
    input  logic [32*FETCH_WIDTH-1:0] iresp_data,
    output logic [64*FETCH_WIDTH-1:0] pcF,
    output logic [FETCH_WIDTH-1:0]    validF,
    output logic [32*FETCH_WIDTH-1:0] instrF,
    output logic                      bundle_valid,
    input  logic                      bundle_ready
);

    localparam int          BW         = 32 * FETCH_WIDTH;
    localparam logic [63:0] ALIGN_MASK = ~(64'(FETCH_WIDTH * 4) - 64'd1);
    localparam logic [63:0] WORD_MASK  = 64'(FETCH_WIDTH - 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 state_q;
    logic [63:0]            pc_q;
    logic                   drop_q;
    logic                   bundle_valid_q;
    logic [FETCH_WIDTH-1:0] validF_q;
    logic [BW-1:0]          instrF_q;

    logic [63:0]               aligned_s;
    logic [63:0]               word_off_s;
    logic [FETCH_WIDTH-1:0]    slot_mask_s;
    logic [64*FETCH_WIDTH-1:0] pcF_s;

    // Bundle-aligned address, per-slot PCs and the entry-slot mask derived from pc_q.
    always_comb begin
        aligned_s   = pc_q & ALIGN_MASK;
        word_off_s  = (pc_q >> 2) & WORD_MASK;
        slot_mask_s = '0;
        pcF_s       = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            pcF_s[i*64 +: 64] = aligned_s + 64'(4 * i);
            slot_mask_s[i]    = (64'(i) >= word_off_s);
        end
    end

    // Fetch FSM: pc, drop flag and the held bundle, with redirect taking priority in every state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_REQ;
            pc_q           <= PC_RESET;
            drop_q         <= 1'b0;
            bundle_valid_q <= 1'b0;
            validF_q       <= '0;
            instrF_q       <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        // An accepted request is still in flight; its response must be discarded.
                        if (ireq_ready) begin
                            state_q <= S_WAIT;
                            drop_q  <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end else if (ireq_ready) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        if (iresp_valid) begin
                            state_q <= S_REQ;
                            drop_q  <= 1'b0;
                        end else begin
                            state_q <= S_WAIT;
                            drop_q  <= 1'b1;
                        end
                    end else if (iresp_valid) begin
                        if (drop_q) begin
                            state_q <= S_REQ;
                            drop_q  <= 1'b0;
                        end else begin
                            state_q        <= S_HOLD;
                            bundle_valid_q <= 1'b1;
                            validF_q       <= slot_mask_s;
                            instrF_q       <= iresp_data;
                        end
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_q           <= redirect_pc;
                        state_q        <= S_REQ;
                        bundle_valid_q <= 1'b0;
                        validF_q       <= '0;
                    end else if (bundle_ready) begin
                        pc_q           <= pc_nxt;
                        state_q        <= S_REQ;
                        bundle_valid_q <= 1'b0;
                        validF_q       <= '0;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                default: begin
                    state_q        <= S_REQ;
                    drop_q         <= 1'b0;
                    bundle_valid_q <= 1'b0;
                    validF_q       <= '0;
                end
            endcase
        end
    end

    assign ireq_valid   = (state_q == S_REQ);
    assign ireq_addr    = aligned_s;
    assign pcF          = pcF_s;
    assign validF       = validF_q;
    assign instrF       = instrF_q;
    assign bundle_valid = bundle_valid_q;

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- FETCH_WIDTH, 2, instructions per fetch bundle (power of 2)
- PC_RESET, 64'h8000_0000, PC value after reset
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- pc_nxt  in  64  next sequential/predicted PC from next-PC select logic
- redirect_valid  in  1  backend redirect (mispredict/exception)
- redirect_pc  in  64  redirect target
- ireq_valid  out  1  I-cache request valid
- ireq_addr  out  64  bundle-aligned fetch address
- ireq_ready  in  1  I-cache accepts request
- iresp_valid  in  1  I-cache response valid (one cycle pulse)
- iresp_data  in  32*FETCH_WIDTH  bundle instructions, slot 0 in LSBs
- pcF  out  64*FETCH_WIDTH  per-slot PC of current bundle
- validF  out  FETCH_WIDTH  per-slot valid of current bundle
- instrF  out  32*FETCH_WIDTH  per-slot instruction
- bundle_valid  out  1  bundle presented downstream
- bundle_ready  in  1  downstream accepts bundle

Function
REQ-003 Internal registers: pc (64), FSM state, held bundle, drop flag.
REQ-004 FSM states: REQ, WAIT, HOLD.
REQ-005 REQ: ireq_valid=1, ireq_addr = pc with low log2(FETCH_WIDTH*4) bits cleared; ireq_valid&ireq_ready -> WAIT.
REQ-006 WAIT: ireq_valid=0; iresp_valid with drop=0 -> capture bundle, go HOLD; iresp_valid with drop=1 -> clear drop, go REQ.
REQ-007 HOLD: bundle_valid=1; bundle_valid&bundle_ready -> pc <= pc_nxt, go REQ same edge.
REQ-008 Slot i: pcF[i] = aligned address + 4*i; validF[i] = 1 iff slot index >= pc word offset within bundle; validF = 0 outside HOLD.
REQ-009 instrF reflects captured bundle only; iresp_data not passed through combinationally.
REQ-010 Minimum latency request-accept to bundle_valid: 1 cycle after iresp_valid edge (registered output).
REQ-011 Redirect priority highest: redirect_valid in any state -> pc <= redirect_pc, bundle_valid deasserts next cycle.
REQ-012 Redirect in REQ or HOLD -> next state REQ; in WAIT with no same-cycle iresp_valid -> stay WAIT, drop <= 1; in WAIT with same-cycle iresp_valid -> response discarded, go REQ, drop <= 0.
REQ-013 Redirect in REQ coincident with ireq_ready: request counted as issued -> WAIT, drop <= 1.
REQ-014 Redirect and bundle_ready same cycle in HOLD: redirect wins, pc_nxt ignored.
REQ-015 At most one outstanding I-cache request; ireq_valid never asserted in WAIT/HOLD.
REQ-016 ireq_addr stable while ireq_valid=1 and ireq_ready=0 unless redirect.
REQ-017 pc arithmetic 64-bit, wraps modulo 2^64 without flag.

Reset
REQ-018 resetn=0 asynchronously forces: pc=PC_RESET, state=REQ, drop=0, bundle_valid=0, validF=0, instrF=0.
REQ-019 After resetn deasserts, ireq_valid=1 with ireq_addr=aligned PC_RESET on the first clock.
REQ-020 Reset during WAIT: pending response arriving after reset released is treated as response to the new REQ only if issued after release; I-cache is reset by the same resetn.

Verification
REQ-021 Reset release, ireq_ready=1, iresp_valid 2 cycles later with data {0x00000013,0x00100093} -> bundle_valid=1, pcF={0x80000000,0x80000004}, validF=2'b11.
REQ-022 pc=0x80000004 (FETCH_WIDTH=2) -> ireq_addr=0x80000000, validF=2'b10, pcF[1]=0x80000004.
REQ-023 HOLD with bundle_ready=0 for 5 cycles -> outputs stable, ireq_valid=0; then bundle_ready=1, pc_nxt=0x80000100 -> next ireq_addr=0x80000100.
REQ-024 Redirect to 0x80002000 in WAIT, response 3 cycles later -> response dropped, bundle_valid stays 0, next ireq_addr=0x80002000.
REQ-025 Redirect to 0x80003000 and bundle_ready=1 same cycle in HOLD with pc_nxt=0x80000008 -> next ireq_addr=0x80003000.
REQ-026 resetn pulsed low mid-HOLD -> bundle_valid=0 immediately (asynchronous), ireq_addr=0x80000000 after release.
